// File: rtl/tlc_pkg.sv
// Shared types and helpers for the traffic-light lamp monitor: FSM states, lamp identities,
// fault codes and the legal lamp-order successor.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_RUN        = 2'd1,
    ST_FAULT      = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LAMP_NONE = 2'd0,
    LAMP_RED  = 2'd1,
    LAMP_YEL  = 2'd2,
    LAMP_GRN  = 2'd3
  } lamp_e;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_MULTI = 3'd1;
  localparam logic [2:0] FC_ORDER = 3'd2;
  localparam logic [2:0] FC_DARK  = 3'd3;
  localparam logic [2:0] FC_YEL   = 3'd4;

  function automatic lamp_e lamp_succ(input lamp_e l);
    lamp_e s;
    case (l)
      LAMP_RED: s = LAMP_YEL;
      LAMP_YEL: s = LAMP_GRN;
      LAMP_GRN: s = LAMP_RED;
      default:  s = LAMP_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tlc_flash_gen.sv
// Half-period divider for the failsafe yellow flash: a down-counter that pulses toggle_o
// at terminal count while enabled; restart reloads it so each fault starts a fresh half period.
module tlc_flash_gen #(
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic restart_i,
  output logic toggle_o
);

  localparam logic [7:0] RELOAD = 8'(FLASH_HALF - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    toggle_o = 1'b0;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      if (cnt_q == 8'd0) begin
        cnt_d    = RELOAD;
        toggle_o = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp monitor between the traffic-light controller and the lamp drivers; latches illegal lamp
// patterns into a flashing-yellow failsafe. Optional TLC_LAMP_MON_FAULT_CNT_EN adds fault_count.
//
// state         | meaning
// ST_WAIT_FIRST | no lamp lit since reset/clear; darkness is legal, any first lamp is legal
// ST_RUN        | mirroring lamps; order, dark and yellow timers are enforced
// ST_FAULT      | failsafe: red/green off, yellow flashing, inputs ignored until fault_clr
module tlc_lamp_monitor
  import tlc_pkg::*;
#(
  parameter int unsigned DARK_MAX   = 4,
  parameter int unsigned YEL_MAX    = 8,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r_in,
  input  logic       y_in,
  input  logic       g_in,
  input  logic       fault_clr,
  output logic       lamp_r,
  output logic       lamp_y,
  output logic       lamp_g,
  output logic       fault,
  output logic [2:0] fault_code
`ifdef TLC_LAMP_MON_FAULT_CNT_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam logic [7:0] DARK_MAX_C = 8'(DARK_MAX);
  localparam logic [7:0] YEL_MAX_C  = 8'(YEL_MAX);

  state_e     state_q, state_d;
  lamp_e      last_q, last_d;
  logic [7:0] dark_q, dark_d, yel_q, yel_d;
  logic       lamp_r_q, lamp_r_d, lamp_y_q, lamp_y_d, lamp_g_q, lamp_g_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;

  logic [1:0] n_lit;
  logic       dark_s, yel_s;
  lamp_e      lit;
  logic [7:0] dark_inc, yel_inc;
  logic [2:0] viol;
  logic       fault_entry;
  logic       flash_en, flash_toggle;

  always_comb begin
    n_lit    = {1'b0, r_in} + {1'b0, y_in} + {1'b0, g_in};
    dark_s   = (n_lit == 2'd0);
    yel_s    = y_in && !r_in && !g_in;
    lit      = r_in ? LAMP_RED : (y_in ? LAMP_YEL : (g_in ? LAMP_GRN : LAMP_NONE));
    dark_inc = sat_inc8(dark_q);
    yel_inc  = sat_inc8(yel_q);

    // Priority chain gives the lowest code when several violations coincide.
    viol = FC_NONE;
    if (n_lit > 2'd1)
      viol = FC_MULTI;
    else if (state_q == ST_RUN && n_lit == 2'd1 && lit != last_q && lit != lamp_succ(last_q))
      viol = FC_ORDER;
    else if (state_q == ST_RUN && dark_s && dark_inc >= DARK_MAX_C)
      viol = FC_DARK;
    else if (yel_s && yel_inc >= YEL_MAX_C)
      viol = FC_YEL;

    fault_entry = (state_q != ST_FAULT) && (viol != FC_NONE);
    flash_en    = (state_q == ST_FAULT) && !fault_clr;
  end

  tlc_flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (flash_en),
    .restart_i (fault_entry),
    .toggle_o  (flash_toggle)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    dark_d   = dark_q;
    yel_d    = yel_q;
    lamp_r_d = lamp_r_q;
    lamp_y_d = lamp_y_q;
    lamp_g_d = lamp_g_q;
    fault_d  = fault_q;
    code_d   = code_q;

    case (state_q)
      ST_FAULT: begin
        if (fault_clr) begin
          state_d  = ST_WAIT_FIRST;
          last_d   = LAMP_NONE;
          dark_d   = 8'd0;
          yel_d    = 8'd0;
          lamp_r_d = 1'b0;
          lamp_y_d = 1'b0;
          lamp_g_d = 1'b0;
          fault_d  = 1'b0;
          code_d   = FC_NONE;
        end else begin
          lamp_y_d = lamp_y_q ^ flash_toggle;
        end
      end
      default: begin
        if (viol != FC_NONE) begin
          state_d  = ST_FAULT;
          dark_d   = 8'd0;
          yel_d    = 8'd0;
          lamp_r_d = 1'b0;
          lamp_y_d = 1'b1;
          lamp_g_d = 1'b0;
          fault_d  = 1'b1;
          code_d   = viol;
        end else begin
          lamp_r_d = r_in;
          lamp_y_d = y_in;
          lamp_g_d = g_in;
          dark_d   = (state_q == ST_RUN && dark_s) ? dark_inc : 8'd0;
          yel_d    = yel_s ? yel_inc : 8'd0;
          if (n_lit == 2'd1) begin
            last_d  = lit;
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT_FIRST;
      last_q   <= LAMP_NONE;
      dark_q   <= 8'd0;
      yel_q    <= 8'd0;
      lamp_r_q <= 1'b0;
      lamp_y_q <= 1'b0;
      lamp_g_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      dark_q   <= dark_d;
      yel_q    <= yel_d;
      lamp_r_q <= lamp_r_d;
      lamp_y_q <= lamp_y_d;
      lamp_g_q <= lamp_g_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  assign lamp_r     = lamp_r_q;
  assign lamp_y     = lamp_y_q;
  assign lamp_g     = lamp_g_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

`ifdef TLC_LAMP_MON_FAULT_CNT_EN
  logic [7:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fault_cnt_d = fault_entry ? sat_inc8(fault_cnt_q) : fault_cnt_q;
  end

  // Only reset clears the tally; fault_clr deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_cnt_q <= 8'd0;
    else        fault_cnt_q <= fault_cnt_d;
  end

  assign fault_count = fault_cnt_q;
`endif

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Self-checking bench for tlc_lamp_monitor: directed scenarios plus random lamp traffic,
// compared each cycle against a lamp-rule reference model.
module tb_tlc_lamp_monitor;

  localparam int DARK_MAX   = 4;
  localparam int YEL_MAX    = 8;
  localparam int FLASH_HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       r_in = 1'b0, y_in = 1'b0, g_in = 1'b0, fault_clr = 1'b0;
  logic       lamp_r, lamp_y, lamp_g, fault;
  logic [2:0] fault_code;
`ifdef TLC_LAMP_MON_FAULT_CNT_EN
  logic [7:0] fault_count;
`endif

  tlc_lamp_monitor #(.DARK_MAX(DARK_MAX), .YEL_MAX(YEL_MAX), .FLASH_HALF(FLASH_HALF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_in       (r_in),
    .y_in       (y_in),
    .g_in       (g_in),
    .fault_clr  (fault_clr),
    .lamp_r     (lamp_r),
    .lamp_y     (lamp_y),
    .lamp_g     (lamp_g),
    .fault      (fault),
    .fault_code (fault_code)
`ifdef TLC_LAMP_MON_FAULT_CNT_EN
    ,
    .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 waiting for first lamp, 1 running, 2 failsafe.
  // Lamps are numbered 1=red, 2=yellow, 3=green, 0=none.
  int m_mode, m_last, m_dk, m_yk, m_fk, m_fcnt;
  bit e_r, e_y, e_g, e_f;
  int e_code;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_last = 0; m_dk = 0; m_yk = 0; m_fk = 0; m_fcnt = 0;
    e_r = 0; e_y = 0; e_g = 0; e_f = 0; e_code = 0;
  endfunction

  function automatic void model_step(bit r, bit y, bit g, bit clr);
    int n, lit, code;
    if (m_mode == 2) begin
      if (clr) begin
        m_mode = 0; m_last = 0; m_dk = 0; m_yk = 0;
        e_r = 0; e_y = 0; e_g = 0; e_f = 0; e_code = 0;
      end else begin
        m_fk++;
        e_y = ((m_fk / FLASH_HALF) % 2) == 0;
      end
      return;
    end
    n    = int'(r) + int'(y) + int'(g);
    lit  = r ? 1 : (y ? 2 : (g ? 3 : 0));
    code = 0;
    if (n > 1) code = 1;
    else if (n == 1 && m_mode == 1 && lit != m_last && lit != (m_last % 3) + 1) code = 2;
    m_dk = (m_mode == 1 && n == 0) ? ((m_dk < 255) ? m_dk + 1 : 255) : 0;
    m_yk = (n == 1 && y) ? ((m_yk < 255) ? m_yk + 1 : 255) : 0;
    if (code == 0 && m_dk >= DARK_MAX) code = 3;
    if (code == 0 && m_yk >= YEL_MAX) code = 4;
    if (code != 0) begin
      m_mode = 2; m_fk = 0; m_dk = 0; m_yk = 0;
      e_r = 0; e_y = 1; e_g = 0; e_f = 1; e_code = code;
      if (m_fcnt < 255) m_fcnt++;
    end else begin
      e_r = r; e_y = y; e_g = g;
      if (n == 1) begin
        m_last = lit;
        m_mode = 1;
      end
    end
  endfunction

  task automatic step(input bit r, input bit y, input bit g, input bit clr, input string tag);
    r_in = r; y_in = y; g_in = g; fault_clr = clr;
    @(posedge clk);
    model_step(r, y, g, clr);
    @(negedge clk);
    fault_clr = 1'b0;
    check(tag, int'({lamp_r, lamp_y, lamp_g, fault, fault_code}),
          int'({e_r, e_y, e_g, e_f, 3'(e_code)}));
`ifdef TLC_LAMP_MON_FAULT_CNT_EN
    check({tag, "_cnt"}, int'(fault_count), m_fcnt);
`endif
  endtask

  task automatic lamp(input int l, input int n, input string tag);
    for (int i = 0; i < n; i++) step(l == 1, l == 2, l == 3, 1'b0, tag);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_async", int'({lamp_r, lamp_y, lamp_g, fault, fault_code}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cur, dur, pick;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", int'({lamp_r, lamp_y, lamp_g, fault, fault_code}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal cycle including a long green hold.
    lamp(0, 3, "wait_dark");
    lamp(1, 6, "norm_r");
    lamp(2, 6, "norm_y");
    lamp(3, 16, "norm_g");
    lamp(1, 6, "norm_r2");
    check("norm_no_fault", int'(fault), 0);

    // Multi-lamp: red+green together.
    step(1, 0, 1, 0, "multi");
    check("multi_code", int'(fault_code), 1);
    check("multi_g_off", int'(lamp_g), 0);
    lamp(3, 5, "multi_hold");
    step(0, 0, 0, 1, "multi_clr");
    check("clr_code", int'(fault_code), 0);

    // Illegal order R -> G.
    lamp(1, 2, "ord_r");
    lamp(3, 1, "ord_g");
    check("order_code", int'(fault_code), 2);
    step(0, 0, 0, 1, "ord_clr");

    // Dark gap transparency then dark timeout.
    lamp(1, 2, "gap_r");
    lamp(0, 2, "gap_dark");
    lamp(2, 2, "gap_y");
    check("gap_no_fault", int'(fault), 0);
    lamp(3, 2, "gap_g");
    lamp(1, 1, "gap_r2");
    lamp(0, 3, "dark3");
    check("dark3_no_fault", int'(fault), 0);
    lamp(0, 1, "dark4");
    check("dark_code", int'(fault_code), 3);
    step(0, 0, 0, 1, "dark_clr");

    // Yellow stuck, then the flash pattern 4 on / 4 off.
    lamp(1, 2, "ys_r");
    lamp(2, YEL_MAX - 1, "ys_y");
    check("ys_no_fault", int'(fault), 0);
    lamp(2, 1, "ys_y8");
    check("ys_code", int'(fault_code), 4);
    check("flash_j0", int'(lamp_y), 1);
    for (int j = 1; j < 3 * FLASH_HALF; j++) begin
      step(1, 1, 1, 0, "flash");
      check("flash_pat", int'(lamp_y), ((j / FLASH_HALF) % 2 == 0) ? 1 : 0);
    end
    step(0, 0, 0, 1, "ys_clr");

    // Green as first lamp after clear is legal.
    lamp(3, 3, "first_g");
    lamp(1, 2, "first_g_r");
    check("first_g_ok", int'(fault), 0);

    // Reset in the middle of the flash.
    step(1, 1, 0, 0, "mid_multi");
    lamp(0, 5, "mid_flash");
    do_reset();

    // Three fault/clear rounds for the fault tally.
    for (int k = 0; k < 3; k++) begin
      lamp(1, 1, "round_r");
      lamp(3, 1, "round_g");
      lamp(0, 2, "round_hold");
      step(0, 0, 0, 1, "round_clr");
    end
`ifdef TLC_LAMP_MON_FAULT_CNT_EN
    check("fcnt_3", int'(fault_count), 3);
`endif

    // Random traffic: mostly legal walks with dark gaps, stray patterns and clears.
    cur = 1;
    for (int b = 0; b < 600; b++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 65) begin
        if ($urandom_range(0, 3) != 0) cur = (cur % 3) + 1;
        dur = (cur == 2) ? int'($urandom_range(1, YEL_MAX + 1)) : int'($urandom_range(1, 8));
        lamp(cur, dur, "rnd_walk");
      end else if (pick < 78) begin
        lamp(0, int'($urandom_range(1, DARK_MAX + 1)), "rnd_dark");
      end else if (pick < 86) begin
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rnd_pat");
      end else if (pick < 98) begin
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, "rnd_clr");
      end else begin
        lamp(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), "rnd_any");
        if ($urandom_range(0, 3) == 0) do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
